// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing constants and the shared-counter width helper.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_e;

    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_GLITCH_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES   = 16;

    // One counter is time-shared between STABILIZE and HOLD, so it is sized for the larger interval.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset to 0,
// shared by the asynchronous inputs of this clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_seq.sv
// Core reset sequencer: releases core_rst_n after PLL lock has been stable,
// filters lock glitches and enforces a minimum reset pulse.
// Optional lock-loss counter enabled by PLL_RESET_SEQ_LOCK_COUNT_EN.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       core_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);

    logic          w_locked_s;
    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [GW-1:0] r_glitch;
    logic [GW-1:0] w_glitch_next;
    logic          w_loss;
    logic          r_core_rst_n;
    logic          r_ready;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = '0;
        w_glitch_next = '0;
        w_loss        = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (soft_rst_req)
                    w_next = HOLD;
                else if (w_locked_s)
                    w_next = STABILIZE;
            end
            STABILIZE: begin
                if (soft_rst_req)
                    w_next = HOLD;
                else if (!w_locked_s)
                    w_next = WAIT_LOCK;
                else if (r_cnt == STABLE_LAST)
                    w_next = RUN;
                else
                    w_cnt_next = r_cnt + 1'b1;
            end
            RUN: begin
                if (!w_locked_s) begin
                    if (r_glitch == GLITCH_LAST)
                        w_loss = 1'b1;
                    else
                        w_glitch_next = r_glitch + 1'b1;
                end
                // Lock loss takes precedence so a coincident soft request still gets counted.
                if (w_loss || soft_rst_req) begin
                    w_next        = HOLD;
                    w_glitch_next = '0;
                end
            end
            HOLD: begin
                if (soft_rst_req)
                    w_cnt_next = '0;
                else if (r_cnt == HOLD_LAST)
                    w_next = WAIT_LOCK;
                else
                    w_cnt_next = r_cnt + 1'b1;
            end
            default: w_next = WAIT_LOCK;
        endcase
    end

    // Outputs are registered from next-state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_glitch     <= '0;
            r_core_rst_n <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_glitch     <= w_glitch_next;
            r_core_rst_n <= (w_next == RUN);
            r_ready      <= (w_next == RUN);
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign ready      = r_ready;

`ifdef PLL_RESET_SEQ_LOCK_COUNT_EN
    logic [7:0] r_loss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_loss_count <= 8'd0;
        else if (w_loss && (r_loss_count != 8'hFF))
            r_loss_count <= r_loss_count + 8'd1;
    end

    assign lock_loss_count = r_loss_count;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule
